// File: rtl/bitwise_seq_if.sv
// Handshake/data bundle for bitwise_seq: start request, operand fields and result flags.
// master drives the request side, slave (the execution unit) drives the result side.
interface bitwise_seq_if #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
);
    localparam int AW = $clog2(NREG);

    logic             s;
    logic [3:0]       op;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rn;
    logic [AW-1:0]    rm;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             z;
    logic             err;
    logic             done;

    modport master (
        output s, op, rd, rn, rm, in,
        input  out, z, err, done
    );

    modport slave (
        input  s, op, rd, rn, rm, in,
        output out, z, err, done
    );
endinterface

// File: rtl/bitwise_seq.sv
// Multi-cycle bitwise execution unit (IDLE->RDA->RDB->EX->WB) over an internal register file.
// Define BITWISE_SEQ_ROL_EN to make op 0111 a rotate-left; otherwise it is illegal.
module bitwise_seq #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input  logic             clk,
    input  logic             reset,
    bitwise_seq_if.slave     bus
);
    localparam int AW = $clog2(NREG);

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_MOV  = 4'b0101;
    localparam logic [3:0] OP_READ = 4'b0110;
    localparam logic [3:0] OP_ROL  = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDA,
        S_RDB,
        S_EX,
        S_WB
    } state_t;

    state_t           state_reg;
    logic [3:0]       op_reg;
    logic [AW-1:0]    rd_reg;
    logic [AW-1:0]    rn_reg;
    logic [AW-1:0]    rm_reg;
    logic [WIDTH-1:0] in_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] c_reg;
    logic             ill_reg;
    logic [WIDTH-1:0] out_reg;
    logic             z_reg;
    logic             err_reg;
    logic             done_reg;

    logic [WIDTH-1:0] rf [NREG];
    logic             wr_en;
    logic [WIDTH-1:0] alu_next;
    logic             ill_next;

    // Write happens only in WB for legal, register-writing ops.
    assign wr_en = (state_reg == S_WB) && !ill_reg && (op_reg != OP_READ);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
            logic [WIDTH-1:0] r_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_reg <= '0;
                end else if (wr_en && (rd_reg == AW'(gi))) begin
                    r_reg <= c_reg;
                end
            end
            assign rf[gi] = r_reg;
        end
    endgenerate

`ifdef BITWISE_SEQ_ROL_EN
    int unsigned              rol_amt;
    logic [2*WIDTH-1:0]       rol_dbl;
    logic [WIDTH-1:0]         rol_res;
    // Rotating the doubled word leaves the wrapped bits in the upper half.
    assign rol_amt = 32'(b_reg % WIDTH);
    assign rol_dbl = {a_reg, a_reg} << rol_amt;
    assign rol_res = rol_dbl[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        alu_next = '0;
        ill_next = 1'b0;
        case (op_reg)
            OP_LOAD: alu_next = in_reg;
            OP_AND:  alu_next = a_reg & b_reg;
            OP_OR:   alu_next = a_reg | b_reg;
            OP_XOR:  alu_next = a_reg ^ b_reg;
            OP_NOT:  alu_next = ~a_reg;
            OP_MOV:  alu_next = a_reg;
            OP_READ: alu_next = a_reg;
`ifdef BITWISE_SEQ_ROL_EN
            OP_ROL:  alu_next = rol_res;
`else
            OP_ROL:  ill_next = 1'b1;
`endif
            default: ill_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            op_reg    <= '0;
            rd_reg    <= '0;
            rn_reg    <= '0;
            rm_reg    <= '0;
            in_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= '0;
            ill_reg   <= 1'b0;
            out_reg   <= '0;
            z_reg     <= 1'b1;
            err_reg   <= 1'b0;
            done_reg  <= 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.s) begin
                        op_reg    <= bus.op;
                        rd_reg    <= bus.rd;
                        rn_reg    <= bus.rn;
                        rm_reg    <= bus.rm;
                        in_reg    <= bus.in;
                        done_reg  <= 1'b0;
                        state_reg <= S_RDA;
                    end
                end
                S_RDA: begin
                    a_reg     <= rf[rn_reg];
                    state_reg <= S_RDB;
                end
                S_RDB: begin
                    b_reg     <= rf[rm_reg];
                    state_reg <= S_EX;
                end
                S_EX: begin
                    c_reg     <= alu_next;
                    ill_reg   <= ill_next;
                    state_reg <= S_WB;
                end
                S_WB: begin
                    // Illegal ops leave out/z untouched and only raise err.
                    if (!ill_reg) begin
                        out_reg <= c_reg;
                        z_reg   <= (c_reg == '0);
                    end
                    err_reg   <= ill_reg;
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: begin
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.out  = out_reg;
    assign bus.z    = z_reg;
    assign bus.err  = err_reg;
    assign bus.done = done_reg;
endmodule
